// File: rtl/pipeline_memory_responder_if.sv
// Bus between the pipeline processor's memory ports and the memory responder.
// Signal names mirror the processor ports so both ends connect by name.
interface pipeline_memory_responder_if #(
    parameter int DATA_WIDTH  = 20,
    parameter int COUNT_WIDTH = 16
);
    logic [19:0]            Daddress;
    logic [DATA_WIDTH-1:0]  DataIn;
    logic [19:0]            MEM_Address_Out;
    logic [DATA_WIDTH-1:0]  MEM_WriteData_Out;
    logic                   MEM_WriteEnable_Out;
    logic [DATA_WIDTH-1:0]  DataIn_Mem;
    logic                   Ready;
    logic                   RangeFault;
    logic                   ProtectFault;
    logic [COUNT_WIDTH-1:0] WriteCount;

    modport master (
        output Daddress, MEM_Address_Out, MEM_WriteData_Out, MEM_WriteEnable_Out,
        input  DataIn, DataIn_Mem, Ready, RangeFault, ProtectFault, WriteCount
    );

    modport slave (
        input  Daddress, MEM_Address_Out, MEM_WriteData_Out, MEM_WriteEnable_Out,
        output DataIn, DataIn_Mem, Ready, RangeFault, ProtectFault, WriteCount
    );
endinterface

// File: rtl/pipeline_memory_responder.sv
// Memory responder for the pipeline processor: one word array serving the
// instruction fetch port and the data load/store port. The array is
// zero-filled after every reset before it answers accesses; out-of-range
// accesses are flagged.
// Optional build macro MEMRESP_PROTECT_EN: write-protects indices below
// PROTECT_LIMIT and reports dropped writes on ProtectFault.
//
// state | meaning
// CLEAR | zero-filling the array one word per cycle, accesses ignored
// RUN   | array initialized, reads and writes served
module pipeline_memory_responder #(
    parameter int          ADDR_BITS     = 8,
    parameter int          DATA_WIDTH    = 20,
    parameter int unsigned PROTECT_LIMIT = 64,
    parameter int          COUNT_WIDTH   = 16
) (
    input logic                         Clock,
    input logic                         Reset,
    pipeline_memory_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

`ifdef MEMRESP_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_ptr_q, clr_ptr_d;
    logic                   range_fault_q, range_fault_d;
    logic                   protect_fault_q, protect_fault_d;
    logic [COUNT_WIDTH-1:0] write_count_q, write_count_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_idx;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    logic [ADDR_BITS-1:0]   f_idx, m_idx;
    logic                   f_oor, m_oor;
    logic                   wr_prot;

    // Address decode: low bits index the array, any upper bit set is out of range.
    always_comb begin
        f_idx   = bus.Daddress[ADDR_BITS-1:0];
        m_idx   = bus.MEM_Address_Out[ADDR_BITS-1:0];
        f_oor   = (bus.Daddress >> ADDR_BITS) != '0;
        m_oor   = (bus.MEM_Address_Out >> ADDR_BITS) != '0;
        wr_prot = PROT_ON && (32'(m_idx) < PROTECT_LIMIT);
    end

    // Next-state: clear sequencing, write acceptance, sticky faults, write counter.
    always_comb begin
        state_d         = state_q;
        clr_ptr_d       = clr_ptr_q;
        range_fault_d   = range_fault_q;
        protect_fault_d = protect_fault_q;
        write_count_d   = write_count_q;
        mem_we          = 1'b0;
        mem_idx         = clr_ptr_q;
        mem_wdata       = '0;

        if (Reset) begin
            state_d         = CLEAR;
            clr_ptr_d       = '0;
            range_fault_d   = 1'b0;
            protect_fault_d = 1'b0;
            write_count_d   = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_idx   = clr_ptr_q;
                    mem_wdata = '0;
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == PTR_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (f_oor || m_oor) begin
                        range_fault_d = 1'b1;
                    end
                    if (bus.MEM_WriteEnable_Out) begin
                        if (m_oor) begin
                            // dropped; fault already raised above
                        end else if (wr_prot) begin
                            protect_fault_d = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_idx   = m_idx;
                            mem_wdata = bus.MEM_WriteData_Out;
                            if (write_count_q != '1) begin
                                write_count_d = write_count_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge Clock) begin
        state_q         <= state_d;
        clr_ptr_q       <= clr_ptr_d;
        range_fault_q   <= range_fault_d;
        protect_fault_q <= protect_fault_d;
        write_count_q   <= write_count_d;
    end

    // Word array: single write port shared by the clear sweep and stores.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    // Zero-latency reads; old word is returned during a same-index write.
    always_comb begin
        bus.DataIn     = '0;
        bus.DataIn_Mem = '0;
        if (!Reset && state_q == RUN) begin
            if (!f_oor) bus.DataIn     = mem_q[f_idx];
            if (!m_oor) bus.DataIn_Mem = mem_q[m_idx];
        end
    end

    // Status outputs.
    always_comb begin
        bus.Ready        = (state_q == RUN);
        bus.RangeFault   = range_fault_q;
        bus.ProtectFault = PROT_ON & protect_fault_q;
        bus.WriteCount   = write_count_q;
    end
endmodule
